aemb_wb_arbiter: RTL and testbench
==================================

AEMB_WB_ARBITER -- requirements
Module: aemb_wb_arbiter

Interface
REQ-001 Parameter TOUT, default 255: bus watchdog limit in clk cycles (range 1..255); counter width is 8 bits.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: one clock; reset is synchronous and active-low (0 = reset).
REQ-004 Port iwb_adr_i, input, 32: instruction-bus address from the aeMB core.
REQ-005 Port iwb_cyc_i, input, 1: instruction-bus cycle request.
REQ-006 Port iwb_stb_i, input, 1: instruction-bus strobe.
REQ-007 Port iwb_sel_i, input, 4: instruction-bus byte selects.
REQ-008 Port iwb_dat_o, output, 32: instruction read data.
REQ-009 Port iwb_ack_o, output, 1: instruction-bus acknowledge.
REQ-010 Port iwb_err_o, output, 1: instruction-bus error.
REQ-011 Port dwb_adr_i, input, 32: data-bus address.
REQ-012 Port dwb_dat_i, input, 32: data-bus write data.
REQ-013 Port dwb_sel_i, input, 4: data-bus byte selects.
REQ-014 Port dwb_cyc_i, input, 1: data-bus cycle request.
REQ-015 Port dwb_stb_i, input, 1: data-bus strobe.
REQ-016 Port dwb_wre_i, input, 1: data-bus write enable.
REQ-017 Port dwb_dat_o, output, 32: data read data.
REQ-018 Port dwb_ack_o, output, 1: data-bus acknowledge.
REQ-019 Port dwb_err_o, output, 1: data-bus error.
REQ-020 Port m_adr_o / m_dat_o / m_sel_o, output, 32/32/4: shared-bus address, write data and byte selects.
REQ-021 Port m_cyc_o / m_stb_o / m_we_o, output, 1 each: shared-bus cycle, strobe and write enable.
REQ-022 Port m_dat_i / m_ack_i / m_err_i, input, 32/1/1: shared-bus read data, acknowledge and error.

Function
REQ-023 Merge the aeMB instruction and data classic-Wishbone masters onto one classic-Wishbone master port (tag 3'b000, no bursts).
REQ-024 Grant FSM states: IDLE, GI (iwb owns the bus), GD (dwb owns the bus); the state is registered.
REQ-025 IDLE transitions: dwb_cyc_i=1 -> GD; else iwb_cyc_i=1 -> GI; else remain in IDLE. Data has priority on a simultaneous request.
REQ-026 Release: in GI or GD, when the owner's cyc_i=0 at the clock edge, go to the other grant state if the other cyc_i=1, else to IDLE.
REQ-027 Ownership is never switched while the owner's cyc_i=1.
REQ-028 Latency: a request seen in IDLE reaches m_cyc_o/m_stb_o one cycle later. A release hand-over has zero idle cycles.
REQ-029 In IDLE, m_cyc_o=m_stb_o=m_we_o=0; m_adr_o, m_dat_o and m_sel_o are don't-care but driven from dwb.
REQ-030 In GI: m_adr_o=iwb_adr_i, m_sel_o=iwb_sel_i, m_cyc_o=iwb_cyc_i, m_stb_o=iwb_stb_i, m_we_o=0, m_dat_o=0.
REQ-031 In GD: the m_* outputs are driven from the dwb inputs, including m_we_o=dwb_wre_i and m_dat_o=dwb_dat_i.
REQ-032 iwb_dat_o=dwb_dat_o=m_dat_i at all times.
REQ-033 iwb_ack_o=m_ack_i only in GI; dwb_ack_o=m_ack_i only in GD; each ack is 0 otherwise.
REQ-034 err outputs: the owner's err_o=m_err_i OR watchdog pulse; a non-owner's err_o=0.
REQ-035 Watchdog counter wd: cleared in IDLE, on m_ack_i, on m_err_i, on any state change, or when m_stb_o=0.
REQ-036 Watchdog increment: otherwise wd increments by 1 per cycle, saturating at 255.
REQ-037 Watchdog expiry: when wd==TOUT-1 with m_stb_o=1 and no ack/err, the owner's err_o is asserted for exactly one cycle and wd clears.
REQ-038 An ack and a watchdog expiry in the same cycle: the ack wins and err_o=0.
REQ-039 m_ack_i or m_err_i arriving in IDLE is ignored.

Reset
REQ-040 While reset=0 at a clock edge, set state=IDLE and wd=0.
REQ-041 From the edge that samples reset=0: m_cyc_o, m_stb_o, m_we_o and all ack/err outputs are 0, regardless of the bus inputs.
REQ-042 A transfer in flight during reset is abandoned with no ack generated.
REQ-043 First grant after reset release: on the first edge with reset=1, follow REQ-025.

Verification
REQ-044 iwb read: iwb_cyc/stb=1, adr=0x100; slave acks 2 cycles later with 0xDEADBEEF -> GI one cycle after request, m_we_o=0, iwb_ack_o=1 with iwb_dat_o=0xDEADBEEF, dwb_ack_o=0.
REQ-045 Simultaneous request: both cyc=1 in IDLE -> GD first, dwb write adr=0x200 dat=0x12345678 sel=0xF m_we_o=1; dwb drops cyc -> GI on the next edge with no IDLE cycle.
REQ-046 Hold grant: iwb keeps cyc=1 for 3 back-to-back acks while dwb requests -> state stays GI; dwb is granted only after iwb_cyc_i=0.
REQ-047 Watchdog: TOUT=4, dwb strobes and the slave never acks -> dwb_err_o=1 for exactly one cycle, 4 cycles after m_stb_o rises; iwb_err_o=0.
REQ-048 Ack versus expiry: the slave acks in the expiry cycle -> dwb_ack_o=1 and dwb_err_o=0.
REQ-049 Reset mid-transfer: reset=0 while in GD with m_stb_o=1 -> m_cyc_o=m_stb_o=0 next cycle; a late m_ack_i=1 produces no ack on either side.

Source files
------------

// File: rtl/aemb_wb_arbiter.sv
// Merges the aeMB instruction and data Wishbone masters onto one classic Wishbone
// master port, with data priority and a per-transfer bus watchdog.
module aemb_wb_arbiter #(
  parameter int unsigned TOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] iwb_adr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  input  logic [3:0]  iwb_sel_i,
  output logic [31:0] iwb_dat_o,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  input  logic [31:0] dwb_adr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  input  logic        dwb_wre_i,
  output logic [31:0] dwb_dat_o,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i
);

  localparam int unsigned WD_W = 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GI   = 2'd1,
    GD   = 2'd2
  } state_t;

  state_t          state;
  logic [WD_W-1:0] wd;
  logic            wd_pulse;

  logic chg_c;
  logic busy_c;
  logic expire_c;
  logic wd_clr_c;
  logic err_c;

  // Grant changes whenever idle sees a request or the owner drops its cycle.
  always_comb begin
    chg_c = 1'b1;
    case (state)
      IDLE:    chg_c = dwb_cyc_i | iwb_cyc_i;
      GI:      chg_c = ~iwb_cyc_i;
      GD:      chg_c = ~dwb_cyc_i;
      default: chg_c = 1'b1;
    endcase
  end

  // Shared-bus mux; address/data/selects follow dwb when nobody owns the bus.
  always_comb begin
    m_adr_o = dwb_adr_i;
    m_dat_o = dwb_dat_i;
    m_sel_o = dwb_sel_i;
    m_cyc_o = 1'b0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    case (state)
      GI: begin
        m_adr_o = iwb_adr_i;
        m_dat_o = '0;
        m_sel_o = iwb_sel_i;
        m_cyc_o = iwb_cyc_i;
        m_stb_o = iwb_stb_i;
      end
      GD: begin
        m_cyc_o = dwb_cyc_i;
        m_stb_o = dwb_stb_i;
        m_we_o  = dwb_wre_i;
      end
      default: ;
    endcase
  end

  assign busy_c   = (state == GI) || (state == GD);
  assign expire_c = busy_c & m_stb_o & ~m_ack_i & ~m_err_i & ~chg_c & (wd == WD_LAST);
  assign wd_clr_c = ~busy_c | m_ack_i | m_err_i | chg_c | ~m_stb_o | expire_c;

  // A pending watchdog error is suppressed by an ack in the same cycle.
  assign err_c = m_err_i | (wd_pulse & ~m_ack_i);

  assign iwb_dat_o = m_dat_i;
  assign dwb_dat_o = m_dat_i;
  assign iwb_ack_o = (state == GI) & m_ack_i;
  assign dwb_ack_o = (state == GD) & m_ack_i;
  assign iwb_err_o = (state == GI) & err_c;
  assign dwb_err_o = (state == GD) & err_c;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wd       <= '0;
      wd_pulse <= 1'b0;
    end else begin
      wd_pulse <= expire_c;
      if (wd_clr_c)
        wd <= '0;
      else if (wd != WD_MAX)
        wd <= wd + WD_W'(1);

      case (state)
        IDLE: begin
          if (dwb_cyc_i)      state <= GD;
          else if (iwb_cyc_i) state <= GI;
        end
        GI: begin
          if (!iwb_cyc_i) state <= dwb_cyc_i ? GD : IDLE;
        end
        GD: begin
          if (!dwb_cyc_i) state <= iwb_cyc_i ? GI : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_wb_arbiter.sv
// Bench for aemb_wb_arbiter: directed cycle table followed by randomized traffic
// checked against a transaction-level ownership/watchdog model.
module tb_aemb_wb_arbiter;

  localparam int unsigned TOUT = 4;
  localparam int NROWS = 34;
  localparam int NRAND = 3000;

  logic        clk;
  logic        reset;
  logic [31:0] iwb_adr_i;
  logic        iwb_cyc_i;
  logic        iwb_stb_i;
  logic [3:0]  iwb_sel_i;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o;
  logic        iwb_err_o;
  logic [31:0] dwb_adr_i;
  logic [31:0] dwb_dat_i;
  logic [3:0]  dwb_sel_i;
  logic        dwb_cyc_i;
  logic        dwb_stb_i;
  logic        dwb_wre_i;
  logic [31:0] dwb_dat_o;
  logic        dwb_ack_o;
  logic        dwb_err_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;
  logic        m_err_i;

  aemb_wb_arbiter #(.TOUT(TOUT)) dut (
    .clk(clk), .reset(reset),
    .iwb_adr_i(iwb_adr_i), .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i),
    .iwb_sel_i(iwb_sel_i), .iwb_dat_o(iwb_dat_o), .iwb_ack_o(iwb_ack_o),
    .iwb_err_o(iwb_err_o),
    .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_sel_i(dwb_sel_i),
    .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i), .dwb_wre_i(dwb_wre_i),
    .dwb_dat_o(dwb_dat_o), .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_sel_o(m_sel_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs: {reset, icyc, istb, dcyc, dstb, dwre, ack, err}
  // ctl:    {m_cyc, m_stb, m_we, iack, dack, ierr, derr}
  typedef struct {
    logic [7:0] in;
    logic [6:0] ctl;
  } vec_t;

  vec_t vec [NROWS];

  int n_chk;
  int n_fail;

  // Reference model: who owns the bus, how long the owner has been stalled,
  // and whether a timeout error is due this cycle.
  int owner;
  int waited;
  bit pend;

  task automatic drive(input logic [7:0] v);
    {reset, iwb_cyc_i, iwb_stb_i, dwb_cyc_i, dwb_stb_i, dwb_wre_i, m_ack_i, m_err_i} = v;
  endtask

  task automatic model_expect(output logic [138:0] e);
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        cyc, stb, we, ia, da, ie, de, errb;
    adr = dwb_adr_i; dat = dwb_dat_i; sel = dwb_sel_i;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (owner == 1) begin
      adr = iwb_adr_i; dat = 32'h0; sel = iwb_sel_i;
      cyc = iwb_cyc_i; stb = iwb_stb_i;
    end else if (owner == 2) begin
      cyc = dwb_cyc_i; stb = dwb_stb_i; we = dwb_wre_i;
    end
    errb = m_err_i | (pend & ~m_ack_i);
    ia = (owner == 1) & m_ack_i;
    da = (owner == 2) & m_ack_i;
    ie = (owner == 1) & errb;
    de = (owner == 2) & errb;
    e = {adr, dat, sel, cyc, stb, we, m_dat_i, ia, ie, m_dat_i, da, de};
  endtask

  task automatic model_step();
    int  nxt;
    bit  stb_now, expire;
    if (!reset) begin
      owner = 0; waited = 0; pend = 0;
      return;
    end
    case (owner)
      1:       nxt = iwb_cyc_i ? 1 : (dwb_cyc_i ? 2 : 0);
      2:       nxt = dwb_cyc_i ? 2 : (iwb_cyc_i ? 1 : 0);
      default: nxt = dwb_cyc_i ? 2 : (iwb_cyc_i ? 1 : 0);
    endcase
    stb_now = (owner == 1) ? iwb_stb_i : ((owner == 2) ? dwb_stb_i : 1'b0);
    expire  = (owner != 0) && stb_now && !m_ack_i && !m_err_i &&
              (nxt == owner) && (waited == int'(TOUT) - 1);
    if (owner == 0 || m_ack_i || m_err_i || nxt != owner || !stb_now || expire)
      waited = 0;
    else if (waited < 255)
      waited = waited + 1;
    pend  = expire;
    owner = nxt;
  endtask

  task automatic do_cycle(input logic [7:0] v, input bit use_tbl,
                          input logic [6:0] ctl_exp, input int tag);
    logic [138:0] e, a;
    logic [6:0]   ctl;
    @(negedge clk);
    drive(v);
    #1;
    model_expect(e);
    a = {m_adr_o, m_dat_o, m_sel_o, m_cyc_o, m_stb_o, m_we_o,
         iwb_dat_o, iwb_ack_o, iwb_err_o, dwb_dat_o, dwb_ack_o, dwb_err_o};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL model[%0d] owner=%0d got=%h want=%h", tag, owner, a, e);
    end
    if (use_tbl) begin
      ctl = {m_cyc_o, m_stb_o, m_we_o, iwb_ack_o, dwb_ack_o, iwb_err_o, dwb_err_o};
      n_chk++;
      if (ctl !== ctl_exp) begin
        n_fail++;
        $display("FAIL row[%0d] ctl got=%b want=%b", tag, ctl, ctl_exp);
      end
    end
    @(posedge clk);
    model_step();
  endtask

  initial begin
    logic [7:0] v;
    bit icyc, dcyc;
    n_chk = 0; n_fail = 0;
    owner = 0; waited = 0; pend = 0;

    vec[0]  = '{8'b0111_1111, 7'b0000000};  // reset masks everything
    vec[1]  = '{8'b1110_0000, 7'b0000000};  // iwb request seen in IDLE
    vec[2]  = '{8'b1110_0000, 7'b1100000};  // GI one cycle later
    vec[3]  = '{8'b1110_0010, 7'b1101000};  // iwb ack
    vec[4]  = '{8'b1000_0000, 7'b0000000};
    vec[5]  = '{8'b1111_1100, 7'b0000000};  // simultaneous request
    vec[6]  = '{8'b1111_1100, 7'b1110000};  // data wins, write
    vec[7]  = '{8'b1111_1110, 7'b1110100};
    vec[8]  = '{8'b1110_0000, 7'b0000000};  // dwb drops, hand-over
    vec[9]  = '{8'b1111_1110, 7'b1101000};  // GI with no idle gap
    vec[10] = '{8'b1111_1110, 7'b1101000};  // held while dwb waits
    vec[11] = '{8'b1111_1110, 7'b1101000};
    vec[12] = '{8'b1001_1100, 7'b0000000};  // iwb releases
    vec[13] = '{8'b1001_1100, 7'b1110000};  // stb rises, no ack
    vec[14] = '{8'b1001_1100, 7'b1110000};
    vec[15] = '{8'b1001_1100, 7'b1110000};
    vec[16] = '{8'b1001_1100, 7'b1110000};
    vec[17] = '{8'b1001_1100, 7'b1110001};  // watchdog error, one cycle
    vec[18] = '{8'b1001_1100, 7'b1110000};
    vec[19] = '{8'b1001_1100, 7'b1110000};
    vec[20] = '{8'b1001_1110, 7'b1110100};  // ack at expiry count
    vec[21] = '{8'b1001_1100, 7'b1110000};
    vec[22] = '{8'b1001_1100, 7'b1110000};
    vec[23] = '{8'b1001_1100, 7'b1110000};
    vec[24] = '{8'b1001_1100, 7'b1110000};
    vec[25] = '{8'b1001_1110, 7'b1110100};  // ack beats pending error
    vec[26] = '{8'b1001_1100, 7'b1110000};
    vec[27] = '{8'b0001_1100, 7'b1110000};  // reset mid-transfer
    vec[28] = '{8'b0001_1110, 7'b0000000};  // late ack dropped
    vec[29] = '{8'b1001_1110, 7'b0000000};  // first grant after reset
    vec[30] = '{8'b1001_1100, 7'b1110000};
    vec[31] = '{8'b1001_1101, 7'b1110001};  // slave error to owner
    vec[32] = '{8'b1000_0000, 7'b0000000};
    vec[33] = '{8'b1000_0011, 7'b0000000};  // ack/err ignored in IDLE

    iwb_adr_i = 32'h0000_0100; iwb_sel_i = 4'hF;
    dwb_adr_i = 32'h0000_0200; dwb_dat_i = 32'h1234_5678; dwb_sel_i = 4'hF;
    m_dat_i   = 32'hDEAD_BEEF;
    drive(8'h00);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NROWS; i++)
      do_cycle(vec[i].in, 1'b1, vec[i].ctl, i);

    icyc = 1'b0; dcyc = 1'b0;
    for (int i = 0; i < NRAND; i++) begin
      if ($urandom_range(3) == 0) icyc = ~icyc;
      if ($urandom_range(3) == 0) dcyc = ~dcyc;
      v[7] = ($urandom_range(99) != 0);
      v[6] = icyc;
      v[5] = icyc & ($urandom_range(3) != 0);
      v[4] = dcyc;
      v[3] = dcyc & ($urandom_range(3) != 0);
      v[2] = 1'($urandom_range(1));
      v[1] = ($urandom_range(3) == 0);
      v[0] = ($urandom_range(15) == 0);
      iwb_adr_i = $urandom; iwb_sel_i = 4'($urandom);
      dwb_adr_i = $urandom; dwb_dat_i = $urandom; dwb_sel_i = 4'($urandom);
      m_dat_i   = $urandom;
      do_cycle(v, 1'b0, 7'b0, NROWS + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
